// File: rtl/image_stream_loader.sv
`default_nettype none
// ============================================================================
// Module : image_stream_loader
// Brief  : Buffers an N*N image and streams it out as paced, ready-throttled
//          beats, then idles for a fixed drain period before signalling done.
// Rev    : 1.0  initial release
// ============================================================================
module image_stream_loader #(
    parameter int N            = 8,
    parameter int pixelWidth   = 8,
    parameter int PACE         = 2,
    parameter int DRAIN_CYCLES = 320,
    parameter int bitSize      = $clog2(N*N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_en,
    input  logic [bitSize-1:0]    ld_addr,
    input  logic [pixelWidth-1:0] ld_data,
    input  logic                  start,
    input  logic                  ready,
    output logic                  we,
    output logic [pixelWidth-1:0] data_out,
    output logic [bitSize-1:0]    pix_addr,
    output logic                  busy,
    output logic                  done
);

    localparam int c_NPIX    = N * N;
    localparam int c_PACE_W  = (PACE > 1) ? $clog2(PACE + 1) : 1;
    localparam int c_DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [c_PACE_W-1:0]  c_PACE_LAST  = c_PACE_W'(PACE - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST =
        c_DRAIN_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
    localparam logic [bitSize-1:0]   c_ADDR_LAST  = bitSize'(c_NPIX - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state,     w_state;
    logic [c_PACE_W-1:0]     r_pace_cnt,  w_pace_cnt;
    logic [c_DRAIN_W-1:0]    r_drain_cnt, w_drain_cnt;
    logic [pixelWidth-1:0]   r_data,      w_data;
    logic [bitSize-1:0]      r_addr,      w_addr;
    logic                    r_we,        w_we;

    logic [pixelWidth-1:0]   r_buf [c_NPIX];
    logic                    w_ld_ok;
    logic [bitSize-1:0]      w_rd_addr;
    logic [pixelWidth-1:0]   w_rd_data;

    // Loads are only accepted while no stream is reading the buffer.
    assign w_ld_ok = ld_en && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            r_buf[ld_addr] <= ld_data;
        end
    end

    // Read is combinational so a same-edge write is not yet visible.
    assign w_rd_addr = (r_state == S_STREAM) ? (r_addr + bitSize'(1)) : '0;
    assign w_rd_data = r_buf[w_rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pace_cnt  <= '0;
            r_drain_cnt <= '0;
            r_data      <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pace_cnt  <= w_pace_cnt;
            r_drain_cnt <= w_drain_cnt;
            r_data      <= w_data;
            r_addr      <= w_addr;
            r_we        <= w_we;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_pace_cnt  = r_pace_cnt;
        w_drain_cnt = r_drain_cnt;
        w_data      = r_data;
        w_addr      = r_addr;
        w_we        = r_we;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state     = S_STREAM;
                    w_data      = w_rd_data;
                    w_addr      = '0;
                    w_we        = 1'b1;
                    w_pace_cnt  = '0;
                    w_drain_cnt = '0;
                end
            end
            S_STREAM: begin
                if (r_pace_cnt == c_PACE_LAST) begin
                    if (ready) begin
                        w_pace_cnt = '0;
                        if (r_addr == c_ADDR_LAST) begin
                            // Last pixel stays on data_out through drain.
                            w_we        = 1'b0;
                            w_addr      = '0;
                            w_drain_cnt = '0;
                            w_state     = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                        end else begin
                            w_data = w_rd_data;
                            w_addr = r_addr + bitSize'(1);
                        end
                    end
                end else begin
                    w_pace_cnt = r_pace_cnt + c_PACE_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_state = S_DONE;
                end else begin
                    w_drain_cnt = r_drain_cnt + c_DRAIN_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign we       = r_we;
    assign data_out = r_data;
    assign pix_addr = r_addr;
    assign busy     = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_image_stream_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_image_stream_loader
// Brief  : Self-checking bench for image_stream_loader (two parameter sets).
// Rev    : 1.0  initial release
// ============================================================================
module tb_image_stream_loader;

    localparam int NPIX    = 64;
    localparam int PACE_A  = 2;
    localparam int DRAIN_A = 320;
    localparam int PACE_B  = 1;
    localparam int DRAIN_B = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld_en_a, ld_en_b;
    logic [5:0] ld_addr;
    logic [7:0] ld_data;
    logic       start_a, start_b;
    logic       ready;

    logic       a_we, a_busy, a_done;
    logic [7:0] a_data;
    logic [5:0] a_addr;
    logic       b_we, b_busy, b_done;
    logic [7:0] b_data;
    logic [5:0] b_addr;

    int vec_cnt = 0;
    int miscmp  = 0;

    logic [7:0] mem [2][NPIX];

    always #5 clk = ~clk;

    image_stream_loader #(.N(8), .pixelWidth(8), .PACE(PACE_A), .DRAIN_CYCLES(DRAIN_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en_a), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start_a), .ready(ready), .we(a_we), .data_out(a_data), .pix_addr(a_addr),
        .busy(a_busy), .done(a_done));

    image_stream_loader #(.N(8), .pixelWidth(8), .PACE(PACE_B), .DRAIN_CYCLES(DRAIN_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en_b), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start_b), .ready(ready), .we(b_we), .data_out(b_data), .pix_addr(b_addr),
        .busy(b_busy), .done(b_done));

    typedef struct {
        logic       ld;
        logic [5:0] la;
        logic [7:0] ldat;
        logic       st;
        logic       rdy;
        logic       e_we;
        logic [7:0] e_d;
        logic [5:0] e_a;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic load_px(input int addr, input logic [7:0] d);
        ld_en_a = 1'b1;
        ld_en_b = 1'b1;
        ld_addr = 6'(addr);
        ld_data = d;
        @(negedge clk);
        ld_en_a = 1'b0;
        ld_en_b = 1'b0;
        mem[0][addr] = d;
        mem[1][addr] = d;
    endtask

    task automatic sample(input bit which, output logic s_we, output logic [7:0] s_d,
                          output logic [5:0] s_a, output logic s_busy, output logic s_done);
        if (which) begin
            s_we = b_we; s_d = b_data; s_a = b_addr; s_busy = b_busy; s_done = b_done;
        end else begin
            s_we = a_we; s_d = a_data; s_a = a_addr; s_busy = a_busy; s_done = a_done;
        end
    endtask

    // mode 0: ready high, 1: ready low 5 stall cycles at pixel 10, 2: random ready.
    // poke: write addr 5 mid-stream and pulse start mid-drain (both must be ignored).
    // ld0: write 0x55 to addr 0 on the start cycle (takes effect for the next run).
    task automatic run_stream(input bit which, input int mode, input bit poke, input bit ld0);
        int         w, pace, drain, n, p, h10, hold10, cnt;
        logic       s_we, s_busy, s_done;
        logic [7:0] s_d;
        logic [5:0] s_a;
        logic [7:0] tr_d [$];
        logic [5:0] tr_a [$];
        bit         tr_r [$];

        w     = which ? 1 : 0;
        pace  = which ? PACE_B : PACE_A;
        drain = which ? DRAIN_B : DRAIN_A;

        ready = 1'b1;
        if (ld0) begin
            ld_addr = 6'd0;
            ld_data = 8'h55;
            if (which) ld_en_b = 1'b1; else ld_en_a = 1'b1;
        end
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; ld_en_a = 1'b0; ld_en_b = 1'b0;

        n = 0; hold10 = 0;
        sample(which, s_we, s_d, s_a, s_busy, s_done);
        while (s_we && n < 4000) begin
            case (mode)
                1: begin
                    ready = 1'b1;
                    if (s_a == 6'd10) begin
                        if (hold10 >= 1 && hold10 <= 5) ready = 1'b0;
                        hold10++;
                    end
                end
                2:       ready = ($urandom_range(0, 3) != 0);
                default: ready = 1'b1;
            endcase
            ld_addr = 6'd5;
            ld_data = 8'hAA;
            if (which) ld_en_b = poke && (n == 3); else ld_en_a = poke && (n == 3);
            tr_d.push_back(s_d);
            tr_a.push_back(s_a);
            tr_r.push_back(ready);
            n++;
            @(negedge clk);
            sample(which, s_we, s_d, s_a, s_busy, s_done);
        end
        ld_en_a = 1'b0; ld_en_b = 1'b0; ready = 1'b1;

        // Pixel i is shown for at least pace cycles, then until ready is seen high.
        p = 0; h10 = 0;
        for (int i = 0; i < NPIX; i++) begin
            int         h;
            logic [7:0] gd;
            logic [5:0] ga;
            h = 0;
            for (int j = pace - 1; p + j < n; j++) begin
                if (tr_r[p + j]) begin
                    h = j + 1;
                    break;
                end
            end
            if (h == 0) begin
                vec_cnt++; miscmp++;
                $display("FAIL pixel_missing: pixel %0d absent, got %0d trace cycles, required more", i, n);
                break;
            end
            gd = tr_d[p]; ga = tr_a[p];
            for (int j = 0; j < h; j++) begin
                if (tr_d[p + j] !== mem[w][i]) gd = tr_d[p + j];
                if (tr_a[p + j] !== 6'(i))     ga = tr_a[p + j];
            end
            chk("pixel_data", gd, mem[w][i]);
            chk("pixel_addr", ga, i);
            if (i == 10) h10 = h;
            p += h;
        end
        chk("stream_cycles", n, p);
        if (mode == 0) chk("stream_total", n, NPIX * pace);
        if (mode == 1) begin
            chk("px10_hold", h10, 7);
            chk("stall_total", n, 133);
        end

        chk("end_addr", s_a, 0);
        chk("end_data", s_d, mem[w][NPIX-1]);
        chk("end_busy", s_busy, (drain > 0) ? 1 : 0);

        cnt = 0;
        while (!s_done && cnt < drain + 50) begin
            if (poke && cnt == 10) begin
                if (which) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            @(negedge clk);
            cnt++;
            sample(which, s_we, s_d, s_a, s_busy, s_done);
        end
        start_a = 1'b0; start_b = 1'b0;
        chk("drain_len", cnt, drain);
        chk("done_busy", s_busy, 0);

        if (ld0) mem[w][0] = 8'h55;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        tbl[0] = '{1'b1, 6'd1, 8'h81, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 6'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 6'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h81, 6'd1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h81, 6'd1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h81, 6'd1, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 6'd2, 8'hEE, 1'b1, 1'b1, 1'b1, 8'h02, 6'd2, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 6'd2, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h03, 6'd3, 1'b1, 1'b0};

        rst_n = 1'b0; ld_en_a = 1'b0; ld_en_b = 1'b0; ld_addr = '0; ld_data = '0;
        start_a = 1'b0; start_b = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_we",   a_we,   0);
        chk("rst_data", a_data, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_b_done", b_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NPIX; i++) load_px(i, 8'(i));

        // Table: write in IDLE, start, pacing, stall, ignored load/start in STREAM.
        for (int i = 0; i < 9; i++) begin
            ld_en_a = tbl[i].ld; ld_addr = tbl[i].la; ld_data = tbl[i].ldat;
            start_a = tbl[i].st; ready = tbl[i].rdy;
            @(negedge clk);
            chk("tbl_we",   a_we,   tbl[i].e_we);
            chk("tbl_data", a_data, tbl[i].e_d);
            chk("tbl_addr", a_addr, tbl[i].e_a);
            chk("tbl_busy", a_busy, tbl[i].e_busy);
            chk("tbl_done", a_done, tbl[i].e_done);
        end
        ld_en_a = 1'b0; start_a = 1'b0; ready = 1'b1;
        mem[0][1] = 8'h81;
        n = 0;
        while (!a_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("tbl_run_done", a_done, 1);
        load_px(1, 8'h01);

        run_stream(1'b0, 0, 1'b0, 1'b0);
        run_stream(1'b0, 1, 1'b0, 1'b0);
        run_stream(1'b1, 0, 1'b0, 1'b0);
        run_stream(1'b1, 2, 1'b0, 1'b0);
        run_stream(1'b0, 2, 1'b1, 1'b0);
        run_stream(1'b0, 0, 1'b0, 1'b0);
        chk("px5_kept", mem[0][5], 8'h05);
        run_stream(1'b0, 0, 1'b0, 1'b1);
        run_stream(1'b0, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream at pixel 30.
        ready = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (a_addr != 6'd30 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_px30", a_addr, 30);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we",   a_we,   0);
        chk("arst_data", a_data, 0);
        chk("arst_addr", a_addr, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_done", a_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_we",   a_we,   0);
        chk("post_rst_busy", a_busy, 0);
        chk("post_rst_done", a_done, 0);
        run_stream(1'b0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int m = 0; m < 8; m++) load_px(int'($urandom_range(0, NPIX - 1)), 8'($urandom));
            run_stream(1'b0, 2, 1'b0, 1'b0);
            run_stream(1'b1, 2, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_stream_loader.md
IMAGE_STREAM_LOADER -- requirements
Module: image_stream_loader

Interface
REQ-001 The module SHALL take parameter N, default 8, meaning the image side length (N*N pixels).
REQ-002 The module SHALL take parameter pixelWidth, default 8, meaning bits per pixel.
REQ-003 The module SHALL take parameter PACE, default 2, meaning the minimum clock cycles per pixel beat; legal range is 1 or more.
REQ-004 The module SHALL take parameter DRAIN_CYCLES, default 320, meaning the idle cycles after the last pixel before done; legal range is 0 or more.
REQ-005 The module SHALL take parameter bitSize, default $clog2(N*N), meaning the address width; it is derived and never set manually.
REQ-006 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 rst_n  input  1  asynchronous reset, active-low.
REQ-008 ld_en  input  1  buffer write strobe.
REQ-009 ld_addr  input  bitSize  buffer write address.
REQ-010 ld_data  input  pixelWidth  buffer write data.
REQ-011 start  input  1  single-cycle request to begin a stream.
REQ-012 ready  input  1  downstream accepts the current beat.
REQ-013 we  output  1  downstream write enable; high only during stream.
REQ-014 data_out  output  pixelWidth  current pixel, registered.
REQ-015 pix_addr  output  bitSize  index of the pixel on data_out.
REQ-016 busy  output  1  high in STREAM and DRAIN.
REQ-017 done  output  1  high in DONE.

Function
REQ-018 The module SHALL hold an internal buffer of N*N x pixelWidth that is written on a rising edge with ld_en=1, in IDLE or DONE only; in STREAM or DRAIN, ld_en SHALL be ignored.
REQ-019 The FSM SHALL have the states IDLE, STREAM, DRAIN and DONE.
REQ-020 IDLE->STREAM on start=1; on that edge the module SHALL set data_out=buf[0], pix_addr=0, we=1, pace_cnt=0.
REQ-021 When ld_en and start occur in the same cycle, the write SHALL complete, and the start-cycle read of buf[0] SHALL return the pre-write contents.
REQ-022 In STREAM, pace_cnt SHALL increment each cycle up to PACE-1 and saturate there.
REQ-023 A beat transfers on a cycle with pace_cnt==PACE-1 and ready=1; the next edge SHALL load buf[pix_addr+1] into data_out, increment pix_addr, and clear pace_cnt.
REQ-024 When ready=0 at pace_cnt==PACE-1, the module SHALL hold data_out, pix_addr and we stable until ready=1.
REQ-025 With PACE=1 and ready held high, the module SHALL transfer one pixel per cycle.
REQ-026 A transfer with pix_addr==N*N-1 SHALL move the FSM to DRAIN, set we=0, hold data_out, and set pix_addr=0, with no wrap beyond N*N-1.
REQ-027 DRAIN SHALL last exactly DRAIN_CYCLES cycles and then enter DONE; with DRAIN_CYCLES=0 the last transfer SHALL go directly to DONE.
REQ-028 DONE SHALL hold done=1; start in DONE SHALL clear done and re-enter STREAM exactly as from IDLE.
REQ-029 start in STREAM or DRAIN SHALL be ignored.
REQ-030 Counters SHALL be sized to hold PACE-1 and DRAIN_CYCLES without overflow.
REQ-031 A full stream with ready held high SHALL take exactly N*N*PACE cycles in STREAM.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for clk, force IDLE and set we=0, data_out=0, pix_addr=0, busy=0, done=0, with all counters cleared.
REQ-033 Buffer contents SHALL NOT be cleared by reset.
REQ-034 Reset asserted mid-STREAM or mid-DRAIN SHALL abort the transfer, and the first edge after release SHALL see IDLE.

Verification
REQ-035 Load 64 pixels with value=index, start, ready=1, N=8, PACE=2 -> data_out sequence 0..63, each held 2 cycles, we high 128 cycles, done exactly 320 cycles after we falls.
REQ-036 Same load, ready low for 5 cycles at pixel 10 -> pixel 10 held 7 cycles, no pixel skipped or duplicated, total STREAM cycles 133.
REQ-037 PACE=1, DRAIN_CYCLES=0, ready=1 -> 64 consecutive beats, done on the cycle after the last beat.
REQ-038 rst_n pulsed low at pixel 30 -> outputs zero asynchronously; a subsequent start restreams from pixel 0 with the preloaded data intact.
REQ-039 Write ld_addr=5 with ld_data=0xAA during STREAM, then restart from DONE -> pixel 5 unchanged; start issued in DRAIN -> no effect.
REQ-040 In DONE, ld_en with ld_addr=0, ld_data=0x55 on the same cycle as start -> first beat shows old buf[0], and the second run after that shows 0x55.
